// File: rtl/matrix_pkg.sv
// Shared constants for the matrix lab: matrix size, SRAM base addresses,
// ASCII codes used by the text loader, and the loader state encoding.
package matrix_pkg;

  localparam int unsigned M_SIZE = 4;

  // SRAM layout shared with the multiplier (column-major matrices)
  localparam int unsigned BASE_A = 0;
  localparam int unsigned BASE_B = M_SIZE * M_SIZE;
  localparam int unsigned BASE_C = 2 * M_SIZE * M_SIZE;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_HASH  = 8'h23;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_SKIP,
    LD_DIGIT,
    LD_COMMIT,
    LD_DONE,
    LD_ERR,
    LD_COMMENT
  } loader_state_t;

  // Classification of one received character
  typedef struct packed {
    logic       is_hex;
    logic       is_sep;
    logic [3:0] nibble;
  } hex_class_t;

endpackage

// File: rtl/uart_matrix_loader_if.sv
// SRAM write port between the matrix loader (master) and the shared SRAM (slave).
//   sram_we   : write strobe
//   sram_addr : word address
//   sram_data : write data
interface uart_matrix_loader_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 18
);
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_data;

  modport master (output sram_we, sram_addr, sram_data);
  modport slave  (input  sram_we, sram_addr, sram_data);
endinterface

// File: rtl/hex_char_decode.sv
// Combinational character classifier for the matrix loader.
//   rx_byte : received ASCII character
//   cls_c   : {is_hex, is_sep, nibble}; nibble valid only when is_hex
module hex_char_decode
  import matrix_pkg::*;
(
  input  logic [7:0] rx_byte,
  output hex_class_t cls_c
);

  always_comb begin
    cls_c = '0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      cls_c.is_hex = 1'b1;
      cls_c.nibble = 4'(rx_byte - 8'h30);
    end else if (rx_byte >= 8'h41 && rx_byte <= 8'h46) begin
      cls_c.is_hex = 1'b1;
      cls_c.nibble = 4'(rx_byte - 8'h37);
    end else if (rx_byte >= 8'h61 && rx_byte <= 8'h66) begin
      cls_c.is_hex = 1'b1;
      cls_c.nibble = 4'(rx_byte - 8'h57);
    end
    cls_c.is_sep = (rx_byte == ASCII_SPACE) || (rx_byte == ASCII_TAB) ||
                   (rx_byte == ASCII_CR)    || (rx_byte == ASCII_LF)  ||
                   (rx_byte == ASCII_COMMA);
  end

endmodule

// File: rtl/uart_matrix_loader.sv
// Parses separator-delimited ASCII hex numbers from the UART receiver and
// writes them into the shared SRAM as matrices A then B, column-major, while
// the text arrives row-major. Raises done once 2*M*M elements are written.
// Optional: LOADER_COMMENT_EN enables '#' ... LF comments in the text.
//   clk, reset_n          : clock, async active-low reset
//   start                 : pulse; arms loader, clears done/error/count
//   received/rx_byte      : received character strobe and data
//   recv_error            : UART framing error strobe
//   sram (master)         : SRAM write port (one sram_we cycle per element)
//   busy/done/error       : status (done and error are sticky until start)
//   elem_count            : elements written since start
module uart_matrix_loader #(
  parameter int unsigned M_SIZE     = 4,
  parameter int unsigned DIGITS     = 5,
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH = 11,
  localparam int unsigned CW        = $clog2(2 * M_SIZE * M_SIZE) + 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       received,
  input  logic [7:0]                 rx_byte,
  input  logic                       recv_error,
  uart_matrix_loader_if.master       sram,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [CW-1:0]              elem_count
);
  import matrix_pkg::*;

  localparam int unsigned MM    = M_SIZE * M_SIZE;
  localparam int unsigned TOTAL = 2 * MM;
  localparam int unsigned AW    = 4 * DIGITS;
  localparam int unsigned NW    = $clog2(DIGITS + 1);

  loader_state_t         state, state_d;
  hex_class_t            cls;
  logic [AW-1:0]         acc, acc_d;
  logic [NW-1:0]         ndig, ndig_d;
  logic                  pend, pend_d;
  logic [CW-1:0]         cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_d, done_d, error_d;
  logic                  is_hash, overflow, digits_full, last_elem;

  // Text index -> SRAM address: matrix base plus column-major offset
  function automatic logic [ADDR_WIDTH-1:0] elem_addr(input logic [CW-1:0] idx);
    int unsigned i;
    i = 32'(idx);
    return ADDR_WIDTH'((i / MM) * MM + (i % M_SIZE) * M_SIZE + (i % MM) / M_SIZE);
  endfunction

  hex_char_decode u_decode (
    .rx_byte (rx_byte),
    .cls_c   (cls)
  );

`ifdef LOADER_COMMENT_EN
  assign is_hash = (rx_byte == ASCII_HASH);
`else
  // Without comment support '#' falls through to the invalid-character path
  assign is_hash = 1'b0;
`endif

  assign overflow    = (acc >> DATA_WIDTH) != '0;
  assign digits_full = (ndig == NW'(DIGITS));
  assign last_elem   = (elem_count == CW'(TOTAL - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= LD_IDLE;
    else          state <= state_d;
  end

  // Next-state logic; start has priority over everything, including a byte
  always_comb begin
    state_d = state;
    if (start) begin
      state_d = LD_SKIP;
    end else begin
      case (state)
        LD_SKIP: begin
          if (recv_error) state_d = LD_ERR;
          else if (received) begin
            if (cls.is_sep)      state_d = LD_SKIP;
            else if (cls.is_hex) state_d = LD_DIGIT;
            else if (is_hash)    state_d = LD_COMMENT;
            else                 state_d = LD_ERR;
          end
        end
        LD_DIGIT: begin
          if (recv_error) state_d = LD_ERR;
          else if (received) begin
            if (cls.is_hex)                state_d = digits_full ? LD_ERR : LD_DIGIT;
            else if (cls.is_sep || is_hash) state_d = LD_COMMIT;
            else                           state_d = LD_ERR;
          end
        end
        LD_COMMIT: begin
          if (overflow)       state_d = LD_ERR;
          else if (last_elem) state_d = LD_DONE;
          else if (pend)      state_d = LD_COMMENT;
          else                state_d = LD_SKIP;
        end
        LD_COMMENT: if (received && rx_byte == ASCII_LF) state_d = LD_SKIP;
        default: state_d = state;
      endcase
    end
  end

  // Datapath and output next values. The SRAM write is launched on the
  // separator so sram_we is high during the single COMMIT cycle.
  always_comb begin
    acc_d  = acc;
    ndig_d = ndig;
    pend_d = pend;
    cnt_d  = elem_count;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (start) begin
      acc_d  = '0;
      ndig_d = '0;
      pend_d = 1'b0;
      cnt_d  = '0;
    end else begin
      case (state)
        LD_SKIP: begin
          if (state_d == LD_DIGIT) begin
            acc_d  = AW'(cls.nibble);
            ndig_d = NW'(1);
          end
        end
        LD_DIGIT: begin
          if (received && state_d == LD_DIGIT) begin
            acc_d  = AW'({acc, cls.nibble});
            ndig_d = ndig + NW'(1);
          end else if (state_d == LD_COMMIT) begin
            we_d   = !overflow;
            addr_d = elem_addr(elem_count);
            data_d = DATA_WIDTH'(acc);
            pend_d = is_hash;
          end
        end
        LD_COMMIT: begin
          pend_d = 1'b0;
          if (!overflow) cnt_d = elem_count + CW'(1);
        end
        default: ;
      endcase
    end
    busy_d  = state_d inside {LD_SKIP, LD_DIGIT, LD_COMMIT, LD_COMMENT};
    done_d  = (state_d == LD_DONE);
    error_d = (state_d == LD_ERR);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      ndig       <= '0;
      pend       <= 1'b0;
      elem_count <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      acc        <= acc_d;
      ndig       <= ndig_d;
      pend       <= pend_d;
      elem_count <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

  assign sram.sram_we   = we_q;
  assign sram.sram_addr = addr_q;
  assign sram.sram_data = data_q;

endmodule
